fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of `icache`. Holds the PC and drives the icache's synchronous, blocking core interface (REN/addr held until hit). Buffers returned instructions with their PCs in a small instruction queue (IQ) for decode. Handles redirects (flush + new PC) and a sticky halt that is forwarded to the icache.

## Interface
Parameters:
- `IQ_DEPTH`, default 4: IQ entries; power of two, ≥2.
- `RESET_PC`, default 32'h0: first fetch address after reset.

Ports:
- `CLK`  in  1  clock, posedge.
- `RST`  in  1  reset; asynchronous, active-high.
- `icache_REN`  out  1  fetch request to icache.
- `icache_addr`  out  32  fetch address; always the current PC.
- `icache_halt`  out  1  halt forwarded to icache.
- `icache_hit`  in  1  icache hit; valid in the same cycle as REN.
- `icache_load`  in  32  instruction word; valid when `icache_hit`.
- `redirect_valid`  in  1  PC redirect from the backend.
- `redirect_pc`  in  32  redirect target.
- `halt_req`  in  1  stop fetching; sticky.
- `iq_valid`  out  1  IQ head valid.
- `iq_instr`  out  32  IQ head instruction.
- `iq_pc`  out  32  IQ head PC.
- `iq_ready`  in  1  decode pops the head when `iq_valid && iq_ready`.
- `fetch_halted`  out  1  unit is in HALT.

## Operation
- States: IDLE, FETCH, HALT.
  - IDLE: entered on reset; goes to FETCH on the first clock edge after `RST` deasserts.
  - FETCH → HALT on `halt_req`.
  - HALT exits only by reset.
- `icache_REN = (state==FETCH) && !iq_full && !redirect_valid && !halt_req`.
- `icache_addr = pc` in every state.
- `icache_halt = fetch_halted = (state==HALT)`.
- Push: when `icache_REN && icache_hit`, push {pc, icache_load} into the IQ and set pc ← pc+4.
  - The PC increments modulo 2^32, so 32'hFFFFFFFC wraps to 32'h0.
- Miss handling: while REN is high and hit is low, pc and addr stay stable. REN cannot drop mid-miss except on redirect or halt, because `iq_full` only changes on a push.
- Redirect (FETCH only):
  - pc ← {redirect_pc[31:2], 2'b00}.
  - The IQ is flushed (count, head and tail → 0).
  - No push occurs that cycle; REN is forced low, so any hit is ignored.
  - A pop in the same cycle is discarded by the flush.
- Halt:
  - `halt_req` in FETCH moves the unit to HALT with no push that cycle.
  - The IQ is not flushed; decode keeps draining it.
  - If `redirect_valid` and `halt_req` arrive together, halt wins: no flush, PC unchanged.
  - `redirect_valid` is ignored in IDLE and HALT.
- IQ:
  - Circular buffer with head/tail pointers of log2(IQ_DEPTH) bits that wrap naturally.
  - Count width is log2(IQ_DEPTH)+1.
  - `iq_full = (count==IQ_DEPTH)`.
  - `iq_valid = (count!=0)`.
  - `iq_instr` and `iq_pc` show the head entry directly from storage. They are 0 when the IQ is empty.
  - Push and pop in the same cycle: count unchanged, both pointers advance. This is legal whenever 0<count<IQ_DEPTH.

## Timing
- Reset values:
  - state IDLE, pc=RESET_PC, count=0, pointers=0.
  - Outputs `icache_REN`=0, `icache_addr`=RESET_PC, `icache_halt`=0, `iq_valid`=0, `iq_instr`=0, `iq_pc`=0, `fetch_halted`=0.
- First REN: 1 cycle after reset deasserts, with addr=RESET_PC.
- Hit latency: 0 cycles (combinational from icache). Data appears on the IQ head on the edge after the hit; decode sees it one cycle after the hit.
- Sustained throughput: 1 instruction/cycle on hits with decode popping every cycle.
- Redirect latency: REN is low in the redirect cycle. The new PC is on `icache_addr` the next cycle, with REN high if the unit is in FETCH.
- `RST` asserted mid-miss: all state clears immediately (asynchronous). REN drops in the same cycle.

## Test plan
- Reset, then icache hits every cycle, decode always ready → `iq_pc` sequence 0,4,8,C with each `iq_instr` matching the injected words; `iq_valid` first rises 2 cycles after reset deasserts.
- `iq_ready`=0 with hits → after 4 pushes `iq_full`, REN=0 with addr=32'h10. Then pop once → REN=1 and the push of 0x10 completes.
- Miss: hold `icache_hit`=0 for 5 cycles at addr 32'h8 → REN=1 and addr=32'h8 stable for all 5 cycles. Hit on cycle 6 → push, then addr=32'hC.
- Redirect with 3 queued entries to `redirect_pc`=32'h1003 in the same cycle as a hit → hit ignored, IQ empty next cycle, addr=32'h1000, REN=1.
- `halt_req` pulse with 2 queued entries → `fetch_halted`=`icache_halt`=1 and REN=0 permanently. Both entries still pop in order. A subsequent redirect is ignored.
- RESET_PC=32'hFFFFFFF8 with hits → PCs FFFFFFF8, FFFFFFFC, 0, 4.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the blocking icache request
// interface and buffers fetched {pc, instr} pairs in a small circular queue
// for decode. Supports backend redirects (flush + new PC) and a sticky halt.
module fetch_unit #(
    parameter int          IQ_DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        CLK,
    input  logic        RST,
    output logic        icache_REN,
    output logic [31:0] icache_addr,
    output logic        icache_halt,
    input  logic        icache_hit,
    input  logic [31:0] icache_load,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        iq_valid,
    output logic [31:0] iq_instr,
    output logic [31:0] iq_pc,
    input  logic        iq_ready,
    output logic        fetch_halted
);

    localparam int PTR_W = $clog2(IQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IQ_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [PTR_W-1:0]  head_q, head_d;
    logic [PTR_W-1:0]  tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;

    // Queue storage; no reset needed because the head is masked when empty.
    logic [31:0] instr_mem [IQ_DEPTH];
    logic [31:0] pc_mem    [IQ_DEPTH];

    logic iq_full;
    logic push;
    logic pop;
    logic flush;

    assign iq_full  = (count_q == FULL_CNT);
    assign iq_valid = (count_q != '0);
    assign iq_instr = iq_valid ? instr_mem[head_q] : 32'h0;
    assign iq_pc    = iq_valid ? pc_mem[head_q]    : 32'h0;
    assign pop      = iq_valid && iq_ready;

    // FSM state register; IDLE holds for exactly the first edge after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: HALT is sticky and only reset leaves it.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (halt_req) state_d = S_HALT;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs: request gating, and redirect qualified so halt takes priority.
    always_comb begin
        icache_REN   = (state_q == S_FETCH) && !iq_full && !redirect_valid && !halt_req;
        icache_halt  = (state_q == S_HALT);
        fetch_halted = (state_q == S_HALT);
        flush        = (state_q == S_FETCH) && redirect_valid && !halt_req;
        push         = icache_REN && icache_hit;
    end

    assign icache_addr = pc_q;

    // Next PC and queue bookkeeping; a flush overrides any pop in the same cycle.
    always_comb begin
        pc_d    = pc_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (flush) begin
            pc_d    = redirect_pc & 32'hFFFF_FFFC;
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                pc_d   = pc_q + 32'd4;
                tail_d = tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_d = head_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // PC and queue pointer registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Queue storage write on every accepted hit.
    always_ff @(posedge CLK) begin
        if (push) begin
            instr_mem[tail_q] <= icache_load;
            pc_mem[tail_q]    <= pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: one task per scenario, inline checks.
// The icache model returns {16'hC0DE, addr[15:0]} so expected words follow
// directly from the expected PC.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        icache_REN;
    logic [31:0] icache_addr;
    logic        icache_halt;
    logic        icache_hit = 1'b0;
    logic [31:0] icache_load;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        halt_req = 1'b0;
    logic        iq_valid;
    logic [31:0] iq_instr;
    logic [31:0] iq_pc;
    logic        iq_ready = 1'b0;
    logic        fetch_halted;

    // Second instance for the PC wrap-around case.
    logic        w_rst = 1'b1;
    logic        w_ren;
    logic [31:0] w_addr;
    logic        w_ihalt;
    logic [31:0] w_load;
    logic        w_iq_valid;
    logic [31:0] w_iq_instr;
    logic [31:0] w_iq_pc;
    logic        w_halted;

    int tests = 0;
    int fails = 0;

    always #5 CLK = ~CLK;

    assign icache_load = {16'hC0DE, icache_addr[15:0]};
    assign w_load      = {16'hC0DE, w_addr[15:0]};

    fetch_unit #(.IQ_DEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .RST(RST),
        .icache_REN(icache_REN), .icache_addr(icache_addr), .icache_halt(icache_halt),
        .icache_hit(icache_hit), .icache_load(icache_load),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .halt_req(halt_req),
        .iq_valid(iq_valid), .iq_instr(iq_instr), .iq_pc(iq_pc), .iq_ready(iq_ready),
        .fetch_halted(fetch_halted)
    );

    fetch_unit #(.IQ_DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut_w (
        .CLK(CLK), .RST(w_rst),
        .icache_REN(w_ren), .icache_addr(w_addr), .icache_halt(w_ihalt),
        .icache_hit(1'b1), .icache_load(w_load),
        .redirect_valid(1'b0), .redirect_pc(32'h0),
        .halt_req(1'b0),
        .iq_valid(w_iq_valid), .iq_instr(w_iq_instr), .iq_pc(w_iq_pc), .iq_ready(1'b1),
        .fetch_halted(w_halted)
    );

    // Reset with given hit/ready levels; returns at the negedge where RST drops.
    task automatic do_reset(input logic hit, input logic rdy);
        RST = 1'b1;
        redirect_valid = 1'b0;
        halt_req = 1'b0;
        icache_hit = hit;
        iq_ready = rdy;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge CLK);
        tests++; if (icache_REN !== 1'b0) begin fails++; $display("FAIL rst_ren got=%b exp=0", icache_REN); end
        tests++; if (icache_addr !== 32'h0) begin fails++; $display("FAIL rst_addr got=%h exp=0", icache_addr); end
        tests++; if (icache_halt !== 1'b0) begin fails++; $display("FAIL rst_ihalt got=%b exp=0", icache_halt); end
        tests++; if (fetch_halted !== 1'b0) begin fails++; $display("FAIL rst_halted got=%b exp=0", fetch_halted); end
        tests++; if (iq_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", iq_valid); end
        tests++; if (iq_instr !== 32'h0) begin fails++; $display("FAIL rst_instr got=%h exp=0", iq_instr); end
        tests++; if (iq_pc !== 32'h0) begin fails++; $display("FAIL rst_pc got=%h exp=0", iq_pc); end
        // Release reset with hits and decode ready; first edge only leaves IDLE.
        icache_hit = 1'b1;
        iq_ready = 1'b1;
        RST = 1'b0;
        #1;
        tests++; if (icache_REN !== 1'b0) begin fails++; $display("FAIL idle_ren got=%b exp=0", icache_REN); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_stream();
        for (int k = 1; k <= 5; k++) begin
            @(negedge CLK);
            tests++; if (icache_REN !== 1'b1) begin fails++; $display("FAIL stream_ren k=%0d got=%b exp=1", k, icache_REN); end
            tests++; if (icache_addr !== 32'(4 * (k - 1))) begin fails++; $display("FAIL stream_addr k=%0d got=%h exp=%h", k, icache_addr, 4 * (k - 1)); end
            tests++; if (iq_valid !== (k >= 2)) begin fails++; $display("FAIL stream_valid k=%0d got=%b exp=%b", k, iq_valid, k >= 2); end
            if (k >= 2) begin
                tests++; if (iq_pc !== 32'(4 * (k - 2))) begin fails++; $display("FAIL stream_pc k=%0d got=%h exp=%h", k, iq_pc, 4 * (k - 2)); end
                tests++; if (iq_instr !== (32'hC0DE0000 | 32'(4 * (k - 2)))) begin fails++; $display("FAIL stream_instr k=%0d got=%h", k, iq_instr); end
            end
            $display("[TB] stream k=%0d addr=%h iq_valid=%b iq_pc=%h", k, icache_addr, iq_valid, iq_pc);
        end
    endtask

    task automatic test_full();
        do_reset(1'b1, 1'b0);
        repeat (4) @(negedge CLK);
        tests++; if (icache_REN !== 1'b1 || icache_addr !== 32'hC) begin fails++; $display("FAIL full_pre ren=%b addr=%h exp 1/0000000c", icache_REN, icache_addr); end
        @(negedge CLK);
        tests++; if (icache_REN !== 1'b0) begin fails++; $display("FAIL full_ren got=%b exp=0", icache_REN); end
        tests++; if (icache_addr !== 32'h10) begin fails++; $display("FAIL full_addr got=%h exp=00000010", icache_addr); end
        tests++; if (iq_pc !== 32'h0) begin fails++; $display("FAIL full_head got=%h exp=0", iq_pc); end
        iq_ready = 1'b1;
        @(negedge CLK);
        tests++; if (icache_REN !== 1'b1 || icache_addr !== 32'h10) begin fails++; $display("FAIL full_resume ren=%b addr=%h exp 1/00000010", icache_REN, icache_addr); end
        tests++; if (iq_pc !== 32'h4) begin fails++; $display("FAIL full_pop got=%h exp=00000004", iq_pc); end
        @(negedge CLK);
        tests++; if (icache_addr !== 32'h14) begin fails++; $display("FAIL full_push_addr got=%h exp=00000014", icache_addr); end
        icache_hit = 1'b0;
        repeat (2) @(negedge CLK);
        tests++; if (iq_pc !== 32'h10 || iq_instr !== 32'hC0DE0010) begin fails++; $display("FAIL full_entry pc=%h instr=%h exp 00000010/c0de0010", iq_pc, iq_instr); end
        $display("[TB] test_full done");
    endtask

    task automatic test_miss();
        do_reset(1'b1, 1'b1);
        repeat (3) @(negedge CLK);
        icache_hit = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge CLK);
            tests++; if (icache_REN !== 1'b1 || icache_addr !== 32'h8) begin fails++; $display("FAIL miss_hold c=%0d ren=%b addr=%h exp 1/00000008", c, icache_REN, icache_addr); end
        end
        icache_hit = 1'b1;
        @(negedge CLK);
        tests++; if (icache_addr !== 32'hC) begin fails++; $display("FAIL miss_after got=%h exp=0000000c", icache_addr); end
        tests++; if (iq_valid !== 1'b1 || iq_pc !== 32'h8) begin fails++; $display("FAIL miss_push valid=%b pc=%h exp 1/00000008", iq_valid, iq_pc); end
        $display("[TB] test_miss done");
    endtask

    task automatic test_redirect();
        do_reset(1'b1, 1'b0);
        repeat (4) @(negedge CLK);
        tests++; if (icache_addr !== 32'hC || iq_pc !== 32'h0) begin fails++; $display("FAIL redir_pre addr=%h head=%h", icache_addr, iq_pc); end
        redirect_valid = 1'b1;
        redirect_pc = 32'h1003;
        iq_ready = 1'b1;
        #1;
        tests++; if (icache_REN !== 1'b0) begin fails++; $display("FAIL redir_ren got=%b exp=0", icache_REN); end
        @(negedge CLK);
        redirect_valid = 1'b0;
        #1;
        tests++; if (iq_valid !== 1'b0 || iq_instr !== 32'h0 || iq_pc !== 32'h0) begin fails++; $display("FAIL redir_flush valid=%b instr=%h pc=%h exp 0/0/0", iq_valid, iq_instr, iq_pc); end
        tests++; if (icache_addr !== 32'h1000 || icache_REN !== 1'b1) begin fails++; $display("FAIL redir_addr addr=%h ren=%b exp 00001000/1", icache_addr, icache_REN); end
        @(negedge CLK);
        tests++; if (iq_pc !== 32'h1000 || iq_instr !== 32'hC0DE1000) begin fails++; $display("FAIL redir_push pc=%h instr=%h", iq_pc, iq_instr); end
        $display("[TB] test_redirect done");
    endtask

    task automatic test_halt();
        do_reset(1'b1, 1'b0);
        repeat (3) @(negedge CLK);
        // Halt and redirect together: halt wins, nothing flushed.
        halt_req = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h3000;
        #1;
        tests++; if (icache_REN !== 1'b0) begin fails++; $display("FAIL halt_ren0 got=%b exp=0", icache_REN); end
        @(negedge CLK);
        halt_req = 1'b0;
        iq_ready = 1'b1;
        #1;
        tests++; if (fetch_halted !== 1'b1 || icache_halt !== 1'b1) begin fails++; $display("FAIL halt_flag halted=%b ihalt=%b exp 1/1", fetch_halted, icache_halt); end
        tests++; if (icache_addr !== 32'h8 || icache_REN !== 1'b0) begin fails++; $display("FAIL halt_addr addr=%h ren=%b exp 00000008/0", icache_addr, icache_REN); end
        tests++; if (iq_valid !== 1'b1 || iq_pc !== 32'h0) begin fails++; $display("FAIL halt_keep valid=%b pc=%h exp 1/0", iq_valid, iq_pc); end
        @(negedge CLK);
        tests++; if (iq_pc !== 32'h4 || iq_instr !== 32'hC0DE0004) begin fails++; $display("FAIL halt_pop2 pc=%h instr=%h", iq_pc, iq_instr); end
        tests++; if (icache_addr !== 32'h8) begin fails++; $display("FAIL halt_redir_ignored addr=%h exp=00000008", icache_addr); end
        @(negedge CLK);
        redirect_valid = 1'b0;
        tests++; if (iq_valid !== 1'b0 || icache_REN !== 1'b0 || fetch_halted !== 1'b1) begin fails++; $display("FAIL halt_end valid=%b ren=%b halted=%b exp 0/0/1", iq_valid, icache_REN, fetch_halted); end
        $display("[TB] test_halt done");
    endtask

    task automatic test_reset_midmiss();
        do_reset(1'b0, 1'b1);
        repeat (3) @(negedge CLK);
        tests++; if (icache_REN !== 1'b1 || icache_addr !== 32'h0) begin fails++; $display("FAIL mm_pre ren=%b addr=%h exp 1/0", icache_REN, icache_addr); end
        RST = 1'b1;
        #1;
        tests++; if (icache_REN !== 1'b0 || icache_addr !== 32'h0) begin fails++; $display("FAIL mm_async ren=%b addr=%h exp 0/0", icache_REN, icache_addr); end
        $display("[TB] test_reset_midmiss done");
    endtask

    task automatic test_wrap();
        logic [31:0] exp_pc [4];
        exp_pc[0] = 32'hFFFF_FFF8;
        exp_pc[1] = 32'hFFFF_FFFC;
        exp_pc[2] = 32'h0000_0000;
        exp_pc[3] = 32'h0000_0004;
        @(negedge CLK);
        tests++; if (w_addr !== 32'hFFFF_FFF8 || w_iq_valid !== 1'b0) begin fails++; $display("FAIL wrap_rst addr=%h valid=%b", w_addr, w_iq_valid); end
        w_rst = 1'b0;
        @(negedge CLK);
        tests++; if (w_ren !== 1'b1 || w_addr !== 32'hFFFF_FFF8) begin fails++; $display("FAIL wrap_first ren=%b addr=%h", w_ren, w_addr); end
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            tests++; if (w_iq_pc !== exp_pc[k] || w_iq_instr !== {16'hC0DE, exp_pc[k][15:0]}) begin fails++; $display("FAIL wrap_pc k=%0d pc=%h instr=%h exp %h", k, w_iq_pc, w_iq_instr, exp_pc[k]); end
            $display("[TB] wrap k=%0d iq_pc=%h", k, w_iq_pc);
        end
        tests++; if (w_ihalt !== 1'b0 || w_halted !== 1'b0) begin fails++; $display("FAIL wrap_halt ihalt=%b halted=%b", w_ihalt, w_halted); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_full();
        test_miss();
        test_redirect();
        test_halt();
        test_reset_midmiss();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
